// File: rtl/bram_dma.sv
// bram_dma: single-channel block copy / block fill engine that masters one port of the lower-RAM block RAM.
// Latency: copy takes 3 cycles per byte (+2 per RAM read retry), fill takes 1 cycle per byte; done follows the last write.
// Backpressure: a read that returns with ram_dr low is retried at the same address; start is ignored while a transfer runs.

module bram_dma #(
    parameter int ADDR_W = 16
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [15:0]       len,
    input  logic [7:0]        fill,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [15:0]       remaining,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_di,
    input  logic [7:0]        ram_do,
    input  logic              ram_dr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_n;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] src_n;
    logic [ADDR_W-1:0] dst_n;
    logic [ADDR_W-1:0] ram_addr_n;
    logic [15:0]       remaining_n;
    logic              mode_q;
    logic              mode_n;
    logic [7:0]        fill_q;
    logic [7:0]        fill_n;
    logic [7:0]        ram_di_n;
    logic              aborted_n;
    logic              busy_n;
    logic              done_n;
    logic              ram_cs_n;
    logic              ram_we_n;

    // State register
    always_ff @(posedge clka) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state decode: abort before a write skips it, abort during a write lets it land first
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len == 16'd0) begin
                        state_n = S_FIN;
                    end else if (mode) begin
                        state_n = S_WR;
                    end else begin
                        state_n = S_RD;
                    end
                end
            end
            S_RD:    state_n = abort ? S_FIN : S_CAP;
            S_CAP: begin
                if (abort) begin
                    state_n = S_FIN;
                end else if (ram_dr) begin
                    state_n = S_WR;
                end else begin
                    state_n = S_RD;
                end
            end
            S_WR: begin
                if (abort || remaining == 16'd1) begin
                    state_n = S_FIN;
                end else if (mode_q) begin
                    state_n = S_WR;
                end else begin
                    state_n = S_RD;
                end
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Next values of pointers and outputs; outputs are decoded from the next state so they are registered
    always_comb begin
        src_n       = src_q;
        dst_n       = dst_q;
        remaining_n = remaining;
        mode_n      = mode_q;
        fill_n      = fill_q;
        ram_di_n    = ram_di;
        aborted_n   = aborted;
        ram_addr_n  = ram_addr;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_n       = src;
                    dst_n       = dst;
                    remaining_n = len;
                    mode_n      = mode;
                    fill_n      = fill;
                    ram_di_n    = fill;
                    aborted_n   = 1'b0;
                end
            end
            S_CAP: begin
                // ram_do is only trusted when the read that just completed flagged ready
                if (ram_dr) begin
                    ram_di_n = ram_do;
                end
            end
            S_WR: begin
                dst_n       = dst_q + ADDR_W'(1);
                remaining_n = remaining - 16'd1;
                if (!mode_q) begin
                    src_n = src_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
        if (abort && (state_q == S_RD || state_q == S_CAP || state_q == S_WR)) begin
            aborted_n = 1'b1;
        end
        if (state_n == S_RD) begin
            ram_addr_n = src_n;
        end else if (state_n == S_WR) begin
            ram_addr_n = dst_n;
        end
        busy_n   = (state_n == S_RD) || (state_n == S_CAP) || (state_n == S_WR);
        done_n   = (state_n == S_FIN);
        ram_cs_n = (state_n == S_RD) || (state_n == S_WR);
        ram_we_n = (state_n == S_WR);
    end

    // Output and datapath registers
    always_ff @(posedge clka) begin
        if (rst) begin
            src_q     <= '0;
            dst_q     <= '0;
            mode_q    <= 1'b0;
            fill_q    <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            remaining <= 16'd0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_di    <= 8'd0;
        end else begin
            src_q     <= src_n;
            dst_q     <= dst_n;
            mode_q    <= mode_n;
            fill_q    <= fill_n;
            busy      <= busy_n;
            done      <= done_n;
            aborted   <= aborted_n;
            remaining <= remaining_n;
            ram_cs    <= ram_cs_n;
            ram_we    <= ram_we_n;
            ram_addr  <= ram_addr_n;
            ram_di    <= ram_di_n;
        end
    end

endmodule

// File: tb/tb_bram_dma.sv
// tb_bram_dma: bench for the block copy / fill engine with a behavioural RAM that can delay reads.
// Latency: each transfer is awaited for a bounded number of cycles.
// Backpressure: the RAM model randomly withholds ram_dr to force read retries.

module tb_bram_dma;

    logic        clka = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] src = 16'd0;
    logic [15:0] dst = 16'd0;
    logic [15:0] len = 16'd0;
    logic [7:0]  fill = 8'd0;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] remaining;
    logic        ram_cs;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_di;
    logic [7:0]  ram_do = 8'd0;
    logic        ram_dr = 1'b0;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        clr = 1'b0;
    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = 16'd0;
    logic [7:0]  bd_dat = 8'd0;
    logic        stall_on = 1'b0;
    int          cs_cnt = 0;
    int          wr_cnt = 0;
    int          stall_cnt = 0;
    int          pass_cnt = 0;
    int          chk_cnt = 0;

    bram_dma #(.ADDR_W(16)) dut (
        .clka(clka), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .src(src), .dst(dst), .len(len), .fill(fill),
        .busy(busy), .done(done), .aborted(aborted), .remaining(remaining),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_do(ram_do), .ram_dr(ram_dr)
    );

    always #5 clka = ~clka;

    // Behavioural RAM port: registered read with ready flag, write, plus bench backdoor
    always @(posedge clka) begin
        if (clr) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_dat;
        end
        if (ram_cs) begin
            cs_cnt <= cs_cnt + 1;
            if (ram_we) begin
                mem[ram_addr] <= ram_di;
                wr_cnt <= wr_cnt + 1;
            end else if (stall_on && $urandom_range(0, 3) == 0) begin
                ram_dr    <= 1'b0;
                stall_cnt <= stall_cnt + 1;
            end else begin
                ram_do <= mem[ram_addr];
                ram_dr <= 1'b1;
            end
        end else begin
            ram_dr <= 1'b0;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] v);
        bd_addr = a;
        bd_dat  = v;
        bd_we   = 1'b1;
        @(posedge clka);
        #1 bd_we = 1'b0;
        ref_mem[a] = v;
    endtask

    // Reference: bytes are moved one at a time in ascending order, addresses wrap at 64 KB
    task automatic model(input logic m, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] n, input logic [7:0] f);
        for (int i = 0; i < int'(n); i++) begin
            logic [15:0] sa;
            logic [15:0] da;
            sa = s + 16'(i);
            da = d + 16'(i);
            ref_mem[da] = m ? f : ref_mem[sa];
        end
    endtask

    function automatic int mem_diff();
        int n;
        n = 0;
        for (int i = 0; i < 65536; i++) begin
            if (mem[i] !== ref_mem[i]) n++;
        end
        return n;
    endfunction

    // Starts one transfer and watches it; cycle k is the k-th cycle after the start edge
    task automatic run(input logic m, input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] n, input logic [7:0] f, input int abort_cyc,
                       output int done_cyc, output int busy_n, output int pulses);
        int  k;
        bit  fin;
        @(negedge clka);
        mode = m; src = s; dst = d; len = n; fill = f; start = 1'b1;
        @(posedge clka);
        #1 start = 1'b0;
        done_cyc = -1; busy_n = 0; pulses = 0; k = 0; fin = 1'b0;
        while (!fin) begin
            @(negedge clka);
            k++;
            abort = (k == abort_cyc);
            if (busy) busy_n++;
            if (done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (done_cyc >= 0 && k >= done_cyc + 2) fin = 1'b1;
            if (k >= 1000) fin = 1'b1;
        end
        abort = 1'b0;
    endtask

    typedef struct {
        logic        m;
        logic [15:0] s;
        logic [15:0] d;
        logic [15:0] n;
        logic [7:0]  f;
        int          exp_done;
        int          exp_cs;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int dc, bc, pc, cs0, wr0, st0, dones, exp_done;
        logic        rm;
        logic [15:0] rs, rd, rn;
        logic [7:0]  rf;

        vecs[0] = '{m: 1'b0, s: 16'h1000, d: 16'h2000, n: 16'd4, f: 8'h00, exp_done: 13, exp_cs: 8};
        vecs[1] = '{m: 1'b1, s: 16'h0000, d: 16'hFFFE, n: 16'd4, f: 8'hA5, exp_done: 5,  exp_cs: 4};
        vecs[2] = '{m: 1'b0, s: 16'h1000, d: 16'h2100, n: 16'd0, f: 8'h00, exp_done: 1,  exp_cs: 0};
        vecs[3] = '{m: 1'b0, s: 16'h3000, d: 16'h3001, n: 16'd3, f: 8'h00, exp_done: 10, exp_cs: 6};
        vecs[4] = '{m: 1'b1, s: 16'h0000, d: 16'h4000, n: 16'd1, f: 8'h3C, exp_done: 2,  exp_cs: 1};

        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
        clr = 1'b1;
        @(posedge clka);
        #1 clr = 1'b0;
        @(posedge clka);
        @(negedge clka);
        chk("reset_state", {busy, done, aborted, remaining, ram_cs, ram_we, ram_addr, ram_di}, 0);
        rst = 1'b0;

        poke(16'h1000, 8'h11); poke(16'h1001, 8'h22); poke(16'h1002, 8'h33); poke(16'h1003, 8'h44);
        poke(16'h3000, 8'h01); poke(16'h3001, 8'h02); poke(16'h3002, 8'h03); poke(16'h3003, 8'h04);
        poke(16'h0002, 8'h5A);

        for (int v = 0; v < 5; v++) begin
            cs0 = cs_cnt;
            run(vecs[v].m, vecs[v].s, vecs[v].d, vecs[v].n, vecs[v].f, -1, dc, bc, pc);
            model(vecs[v].m, vecs[v].s, vecs[v].d, vecs[v].n, vecs[v].f);
            chk($sformatf("vec%0d_done_cycle", v), dc, vecs[v].exp_done);
            chk($sformatf("vec%0d_busy_cycles", v), bc, vecs[v].exp_done - 1);
            chk($sformatf("vec%0d_done_pulses", v), pc, 1);
            chk($sformatf("vec%0d_remaining", v), remaining, 0);
            chk($sformatf("vec%0d_aborted", v), aborted, 0);
            chk($sformatf("vec%0d_cs_cycles", v), cs_cnt - cs0, vecs[v].exp_cs);
            chk($sformatf("vec%0d_mem_diff", v), mem_diff(), 0);
        end

        chk("copy_2000", mem[16'h2000], 8'h11);
        chk("copy_2001", mem[16'h2001], 8'h22);
        chk("copy_2002", mem[16'h2002], 8'h33);
        chk("copy_2003", mem[16'h2003], 8'h44);
        chk("fill_fffe", mem[16'hFFFE], 8'hA5);
        chk("fill_ffff", mem[16'hFFFF], 8'hA5);
        chk("fill_0000", mem[16'h0000], 8'hA5);
        chk("fill_0001", mem[16'h0001], 8'hA5);
        chk("fill_0002_untouched", mem[16'h0002], 8'h5A);
        for (int i = 0; i < 4; i++) chk($sformatf("overlap_%0d", i), mem[16'h3000 + 16'(i)], 8'h01);

        // Abort in the cycle after the third write of an 8-byte copy
        for (int i = 0; i < 8; i++) poke(16'h5000 + 16'(i), 8'h80 + 8'(i));
        wr0 = wr_cnt;
        run(1'b0, 16'h5000, 16'h6000, 16'd8, 8'h00, 10, dc, bc, pc);
        model(1'b0, 16'h5000, 16'h6000, 16'd3, 8'h00);
        chk("abort_writes", wr_cnt - wr0, 3);
        chk("abort_remaining", remaining, 5);
        chk("abort_flag", aborted, 1);
        chk("abort_pulses", pc, 1);
        chk("abort_done_cycle", dc, 11);
        chk("abort_mem_diff", mem_diff(), 0);

        // Reset while the engine is waiting on its first read
        wr0 = wr_cnt;
        @(negedge clka);
        mode = 1'b0; src = 16'h1000; dst = 16'h7000; len = 16'd2; start = 1'b1;
        @(posedge clka);
        #1 start = 1'b0;
        @(negedge clka);
        @(negedge clka);
        rst = 1'b1;
        @(negedge clka);
        chk("rst_outputs", {busy, done, aborted, remaining, ram_cs, ram_we, ram_addr, ram_di}, 0);
        rst = 1'b0;
        dones = 0;
        repeat (2) begin
            @(negedge clka);
            if (done) dones++;
        end
        chk("rst_no_done", dones, 0);
        chk("rst_no_write", wr_cnt - wr0, 0);
        run(1'b1, 16'h0000, 16'h7000, 16'd2, 8'hC3, -1, dc, bc, pc);
        model(1'b1, 16'h0000, 16'h7000, 16'd2, 8'hC3);
        chk("post_rst_done_cycle", dc, 3);
        chk("post_rst_mem_diff", mem_diff(), 0);

        // Randomized transfers with read retries against the reference model
        stall_on = 1'b1;
        for (int r = 0; r < 40; r++) begin
            rm = 1'($urandom_range(0, 1));
            rs = 16'($urandom_range(0, 65535));
            if (r % 5 == 0) rs = 16'hFFFA;
            rn = 16'($urandom_range(1, 10));
            rf = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) rd = rs + 16'($urandom_range(1, 3));
            else rd = 16'($urandom_range(0, 65535));
            for (int i = 0; i < int'(rn); i++) poke(rs + 16'(i), 8'($urandom_range(0, 255)));
            st0 = stall_cnt;
            run(rm, rs, rd, rn, rf, -1, dc, bc, pc);
            model(rm, rs, rd, rn, rf);
            exp_done = rm ? int'(rn) + 1 : 3 * int'(rn) + 1 + 2 * (stall_cnt - st0);
            chk($sformatf("rand%0d_done_cycle", r), dc, exp_done);
            chk($sformatf("rand%0d_remaining", r), remaining, 0);
            chk($sformatf("rand%0d_mem_diff", r), mem_diff(), 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
